// File: rtl/pulse_period_meter.sv
// Pulse period meter: measures clk cycles between pulse events to recover a divider ratio N.
// Latency: one clock from the sampled event to registered period_out/valid_out/locked_out.
// Backpressure: none; valid_out is a one-cycle strobe and period_out holds between updates.
// Optional build macro PULSE_PERIOD_METER_EDGE_DETECT_EN: events are rising edges of pulse_in
// instead of every sampled high cycle.
module pulse_period_meter #(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             enable_in,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             valid_out,
    output logic             locked_out,
    output logic             overflow_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_OVF   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       MATCH_TOP = 4'(LOCK_COUNT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_match;
    logic             r_have_prev;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_locked;
    logic             r_ovf;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_match_nxt;
    logic             w_have_prev_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_valid_nxt;
    logic             w_locked_nxt;
    logic             w_ovf_nxt;
    logic             w_event;

`ifdef PULSE_PERIOD_METER_EDGE_DETECT_EN
    logic r_pulse_q;

    // Previous pulse sample; resets high so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_pulse_q <= 1'b1;
        end else begin
            r_pulse_q <= pulse_in;
        end
    end

    assign w_event = pulse_in & ~r_pulse_q;
`else
    assign w_event = pulse_in;
`endif

    // Next-state and next-output logic; disable clears everything except period_out.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_match_nxt     = r_match;
        w_have_prev_nxt = r_have_prev;
        w_period_nxt    = r_period;
        w_valid_nxt     = 1'b0;
        w_locked_nxt    = r_locked;
        w_ovf_nxt       = r_ovf;

        if (!enable_in) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = '0;
            w_match_nxt     = '0;
            w_have_prev_nxt = 1'b0;
            w_locked_nxt    = 1'b0;
            w_ovf_nxt       = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        w_state_nxt = ST_ARMED;
                        w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ARMED: begin
                    // An event in the saturation cycle wins over overflow.
                    if (w_event) begin
                        w_period_nxt    = r_cnt;
                        w_valid_nxt     = 1'b1;
                        w_cnt_nxt       = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_have_prev_nxt = 1'b1;
                        if (r_have_prev && (r_cnt == r_period)) begin
                            w_match_nxt = (r_match == MATCH_TOP) ? r_match : r_match + 4'd1;
                        end else begin
                            w_match_nxt = 4'd0;
                        end
                        w_locked_nxt = (w_match_nxt == MATCH_TOP);
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt     = ST_OVF;
                        w_ovf_nxt       = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_match_nxt     = 4'd0;
                        w_have_prev_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_OVF: begin
                    // Re-arm only; the gap that overflowed is not a valid period.
                    if (w_event) begin
                        w_state_nxt = ST_ARMED;
                        w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_match     <= '0;
            r_have_prev <= 1'b0;
            r_period    <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_match     <= w_match_nxt;
            r_have_prev <= w_have_prev_nxt;
            r_period    <= w_period_nxt;
            r_valid     <= w_valid_nxt;
            r_locked    <= w_locked_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign period_out   = r_period;
    assign valid_out    = r_valid;
    assign locked_out   = r_locked;
    assign overflow_out = r_ovf;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with CNT_W=8, LOCK_COUNT=4.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
module tb_pulse_period_meter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             srst_n;
    logic             enable_in;
    logic             pulse_in;
    logic [CNT_W-1:0] period_out;
    logic             valid_out;
    logic             locked_out;
    logic             overflow_out;

    int n_chk;
    int n_pass;

    pulse_period_meter #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (4)
    ) dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .enable_in    (enable_in),
        .pulse_in     (pulse_in),
        .period_out   (period_out),
        .valid_out    (valid_out),
        .locked_out   (locked_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    // Drive pulse_in for one cycle, then observe the registered result.
    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    // gap-1 quiet cycles then one pulse cycle: pulse lands gap edges after the previous one.
    task automatic pulse_gap(input int gap);
        for (int i = 0; i < gap - 1; i++) step(1'b0);
        step(1'b1);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        clk       = 1'b0;
        srst_n    = 1'b0;
        enable_in = 1'b1;
        pulse_in  = 1'b0;

        // Reset state
        step(1'b0);
        step(1'b0);
        chk("rst_period", 32'(period_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_locked", 32'(locked_out), 0);
        chk("rst_ovf", 32'(overflow_out), 0);
        srst_n = 1'b1;

        // Divide-by-5: first pulse only arms
        pulse_gap(3);
        chk("div5_first_novalid", 32'(valid_out), 0);
        for (int k = 1; k <= 5; k++) begin
            pulse_gap(5);
            chk("div5_valid", 32'(valid_out), 1);
            chk("div5_period", 32'(period_out), 5);
            chk("div5_locked", 32'(locked_out), (k >= 4) ? 1 : 0);
        end
        step(1'b0);
        chk("div5_strobe_drop", 32'(valid_out), 0);
        chk("div5_period_hold", 32'(period_out), 5);

        // Enable drop while locked; a pulse while disabled is ignored
        enable_in = 1'b0;
        step(1'b0);
        chk("dis_locked", 32'(locked_out), 0);
        chk("dis_ovf", 32'(overflow_out), 0);
        chk("dis_period_hold", 32'(period_out), 5);
        chk("dis_valid", 32'(valid_out), 0);
        step(1'b1);
        chk("dis_pulse_ignored", 32'(valid_out), 0);
        step(1'b0);
        enable_in = 1'b1;
        pulse_gap(2);
        chk("reen_first_novalid", 32'(valid_out), 0);
        for (int k = 1; k <= 4; k++) begin
            pulse_gap(5);
            chk("reen_period", 32'(period_out), 5);
            chk("reen_locked", 32'(locked_out), (k == 4) ? 1 : 0);
        end

        // Period change to 7
        for (int k = 1; k <= 4; k++) begin
            pulse_gap(7);
            chk("div7_valid", 32'(valid_out), 1);
            chk("div7_period", 32'(period_out), 7);
            chk("div7_locked", 32'(locked_out), (k == 4) ? 1 : 0);
        end

        // Minimum period: pulse_in held high
        for (int k = 1; k <= 5; k++) begin
            step(1'b1);
`ifdef PULSE_PERIOD_METER_EDGE_DETECT_EN
            chk("hold_novalid", 32'(valid_out), 0);
            chk("hold_period", 32'(period_out), 7);
            chk("hold_locked", 32'(locked_out), 1);
`else
            chk("min_valid", 32'(valid_out), 1);
            chk("min_period", 32'(period_out), 1);
            chk("min_locked", 32'(locked_out), (k >= 4) ? 1 : 0);
`endif
        end

        // Relock at 5, then reset mid-stream
        for (int k = 1; k <= 5; k++) pulse_gap(5);
        chk("prerst_locked", 32'(locked_out), 1);
        chk("prerst_period", 32'(period_out), 5);
        srst_n = 1'b0;
        step(1'b0);
        chk("midrst_period", 32'(period_out), 0);
        chk("midrst_valid", 32'(valid_out), 0);
        chk("midrst_locked", 32'(locked_out), 0);
        chk("midrst_ovf", 32'(overflow_out), 0);
        srst_n = 1'b1;
        pulse_gap(3);
        chk("postrst_first_novalid", 32'(valid_out), 0);
        pulse_gap(5);
        chk("postrst_valid", 32'(valid_out), 1);
        chk("postrst_period", 32'(period_out), 5);
        chk("postrst_locked", 32'(locked_out), 0);
        for (int k = 1; k <= 3; k++) pulse_gap(5);
        chk("preovf_locked", 32'(locked_out), 1);

        // Overflow: silence after the last pulse
        for (int i = 0; i < 254; i++) step(1'b0);
        chk("ovf_not_yet", 32'(overflow_out), 0);
        step(1'b0);
        chk("ovf_set_at_255", 32'(overflow_out), 1);
        chk("ovf_locked_clr", 32'(locked_out), 0);
        for (int i = 0; i < 45; i++) step(1'b0);
        chk("ovf_sticky", 32'(overflow_out), 1);
        step(1'b1);
        chk("ovf_rearm_novalid", 32'(valid_out), 0);
        pulse_gap(10);
        chk("ovf_after_valid", 32'(valid_out), 1);
        chk("ovf_after_period", 32'(period_out), 10);
        chk("ovf_after_sticky", 32'(overflow_out), 1);
        chk("ovf_after_locked", 32'(locked_out), 0);

        // Disable clears overflow; event at cnt==max wins over overflow
        enable_in = 1'b0;
        step(1'b0);
        chk("dis_ovf_clr", 32'(overflow_out), 0);
        chk("dis_period_hold10", 32'(period_out), 10);
        enable_in = 1'b1;
        pulse_gap(2);
        pulse_gap(255);
        chk("max_valid", 32'(valid_out), 1);
        chk("max_period", 32'(period_out), 255);
        chk("max_no_ovf", 32'(overflow_out), 0);
        step(1'b0);
        chk("max_no_ovf_after", 32'(overflow_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receiver-side counterpart of the ctrdivn divide-by-N counter.
- Consumes a divided pulse stream, e.g. ctrdivn divn_out, and measures the clock-cycle distance between consecutive pulses, which recovers N.
- Reports each measured period, flags lock once the period is stable, and flags overflow when no pulse arrives within the counter range.
- Used as a self-check and monitor beside the divider chain.

Parameters:
- CNT_W, 16, width of the period counter and period_out.
- LOCK_COUNT, 4, number of consecutive identical periods needed to assert locked_out. Legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge.
- srst_n  input  1  synchronous reset, active-low.
- enable_in  input  1  measurement enable. Low clears measurement state.
- pulse_in  input  1  pulse stream under measurement, e.g. divn_out.
- period_out  output  CNT_W  last measured period in clk cycles. Holds between updates.
- valid_out  output  1  one-cycle strobe when period_out is updated.
- locked_out  output  1  high while the last LOCK_COUNT periods are identical.
- overflow_out  output  1  sticky. No pulse within 2^CNT_W-1 cycles.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (srst_n sampled on rising clk edge).
  - Under reset: state=IDLE, cnt=0, match=0, period_out=0, valid_out=0, locked_out=0, overflow_out=0.
  - Reset has priority over every other input, including mid-measurement.
- Event definition: an event is a clk edge at which pulse_in=1 is sampled (default build). Every high cycle is one event.
- States:
  - IDLE: cnt=0. Event with enable_in=1 -> ARMED, cnt<=1. No valid_out.
  - ARMED: each cycle without event, cnt<=cnt+1. On event: period_out<=cnt, valid_out<=1 for one cycle, cnt<=1, stay ARMED.
  - ARMED -> OVF: cnt==2^CNT_W-1 and no event -> OVF, overflow_out<=1, locked_out<=0, match<=0.
  - OVF: cnt holds. Next event -> ARMED, cnt<=1, no valid_out. overflow_out stays set.
- Period arithmetic: events at edges t and t+N give period_out=N, valid_out high in cycle t+N+1. Latency is one clock from the sampled event to the registered outputs. Events on back-to-back cycles give period 1.
- Simultaneous overflow and event: when cnt==max and an event arrives in the same cycle, the event wins. period_out=max and valid_out=1; overflow is not flagged.
- Lock tracking, on each valid update:
  - If new period equals the previous period_out and a previous period exists since IDLE: match<=match+1, saturating at LOCK_COUNT-1. Otherwise match<=0.
  - locked_out<=(new match==LOCK_COUNT-1), registered in the same cycle as valid_out.
  - The first measurement after IDLE or OVF never counts as a match.
- enable_in=0 (checked after reset):
  - Next state IDLE; cnt, match, locked_out and overflow_out are cleared.
  - period_out holds its last value; valid_out=0.
  - Events while disabled are ignored.
- Wrap-around: cnt never wraps. Saturation is handled by the OVF state.

Optional Feature:
- Macro: PULSE_PERIOD_METER_EDGE_DETECT_EN.
- Defined:
  - pulse_in is registered once, and an event is a rising edge (pulse_in=1, previous sample=0).
  - A level held high for many cycles counts as one event; this supports 50% duty-cycle inputs.
  - Event latency grows by zero cycles because the edge is detected from the current and registered samples.
  - The previous-sample register resets to 1, so a pulse_in held high through reset does not produce an event.
- Undefined: every sampled high cycle is an event, as described above.

Test Plan:
- Divide-by-5 lock: srst_n low 2 cycles then high, enable_in=1, one-cycle pulse every 5 cycles.
  - Expect period_out=5 with valid_out once per 5 cycles.
  - locked_out=1 together with the 4th valid (LOCK_COUNT=4).
- Period change: after lock, switch the spacing to 7.
  - The first 7-period valid gives period_out=7 and locked_out=0.
  - locked_out is back to 1 on the 4th consecutive valid with period 7.
- Minimum period: pulse_in held at 1 continuously (default build).
  - valid_out every cycle with period_out=1; locked_out after 4 valids.
  - Edge-detect build: a single event, so no valid_out.
- Overflow: CNT_W=8, one pulse, then silence for 300 cycles.
  - overflow_out=1 exactly 255 cycles after the pulse, and locked_out=0.
  - The next pulse gives no valid; the following pulse 10 cycles later gives period_out=10 with overflow_out still 1.
- Reset mid-operation: srst_n=0 for one cycle during a locked divide-by-5 stream.
  - All outputs read 0 the next cycle.
  - The first valid after reset appears only after two new pulses.
- Enable drop: enable_in=0 for 3 cycles while locked.
  - locked_out=0, overflow_out=0, period_out holds 5.
  - After re-enable, lock returns after 4 more valids.
